fig_plot: RTL and testbench

//  Pixel plotter that sits directly downstream of fig_ring. It consumes the fig_* pixel stream
//  and writes each pixel into an external framebuffer using read-modify-write with "max-V"

---
 rtl/fig_plot.sv | 154 +++++++++++++++
 tb/tb_fig_plot.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fig_plot.sv
// Pixel plotter: read-modify-write of a framebuffer keeping the brightest pixel (max-V),
// plus a full-framebuffer clear sweep.
module fig_plot #(
    parameter int unsigned FB_W   = 240,
    parameter int unsigned FB_H   = 320,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        fig_x_i,
    input  logic [8:0]        fig_y_i,
    input  logic [7:0]        fig_h_i,
    input  logic [7:0]        fig_s_i,
    input  logic [7:0]        fig_v_i,
    input  logic              fig_req_i,
    output logic              fig_ack_o,
    input  logic              clear_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic              fb_re_o,
    input  logic [23:0]       fb_rdata_i,
    output logic              fb_we_o,
    output logic [23:0]       fb_wdata_o,
    output logic [15:0]       drop_cnt_o
);

    typedef enum logic [2:0] {StIdle, StRd, StCmp, StWr, StClr} state_e;

    localparam logic [ADDR_W-1:0] FbWidth  = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_W * FB_H - 1);

    state_e            state_q, state_d;
    logic              clear_pend_q, clear_pend_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [15:0]       drop_q, drop_d;
    logic [7:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic [7:0]        h_q, h_d;
    logic [7:0]        s_q, s_d;
    logic [7:0]        v_q, v_d;

    logic              in_range;
    logic [ADDR_W-1:0] pix_addr;
    logic              unused_rdata;

    assign unused_rdata = ^fb_rdata_i[23:8];

    // Gated by reset so ack stays low while the block is held in reset.
    assign fig_ack_o = reset && (state_q == StIdle) && fig_req_i && !clear_pend_q;
    assign in_range  = (32'(fig_x_i) < FB_W) && (32'(fig_y_i) < FB_H);
    assign pix_addr  = ADDR_W'(y_q) * FbWidth + ADDR_W'(x_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            clear_pend_q <= 1'b0;
            clr_addr_q   <= '0;
            drop_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            h_q          <= '0;
            s_q          <= '0;
            v_q          <= '0;
        end else begin
            state_q      <= state_d;
            clear_pend_q <= clear_pend_d;
            clr_addr_q   <= clr_addr_d;
            drop_q       <= drop_d;
            x_q          <= x_d;
            y_q          <= y_d;
            h_q          <= h_d;
            s_q          <= s_d;
            v_q          <= v_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clear_pend_d = clear_pend_q;
        clr_addr_d   = clr_addr_q;
        drop_d       = drop_q;
        x_d          = x_q;
        y_d          = y_q;
        h_d          = h_q;
        s_d          = s_q;
        v_d          = v_q;

        unique case (state_q)
            StIdle: begin
                if (clear_pend_q) begin
                    state_d      = StClr;
                    clr_addr_d   = '0;
                    clear_pend_d = 1'b0;
                end else if (fig_ack_o) begin
                    x_d = fig_x_i;
                    y_d = fig_y_i;
                    h_d = fig_h_i;
                    s_d = fig_s_i;
                    v_d = fig_v_i;
                    if (in_range) begin
                        state_d = StRd;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            StRd:  state_d = StCmp;
            StCmp: state_d = (v_q > fb_rdata_i[7:0]) ? StWr : StIdle;
            StWr:  state_d = StIdle;
            StClr: begin
                if (clr_addr_q == LastAddr) begin
                    state_d = StIdle;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A pulse always registers, even during a sweep, so another sweep follows.
        if (clear_i) begin
            clear_pend_d = 1'b1;
        end
    end

    always_comb begin
        fb_re_o    = 1'b0;
        fb_we_o    = 1'b0;
        fb_wdata_o = '0;
        fb_addr_o  = '0;
        busy_o     = 1'b0;
        unique case (state_q)
            StRd: begin
                fb_re_o   = 1'b1;
                fb_addr_o = pix_addr;
            end
            StCmp: fb_addr_o = pix_addr;
            StWr: begin
                fb_we_o    = 1'b1;
                fb_wdata_o = {h_q, s_q, v_q};
                fb_addr_o  = pix_addr;
            end
            StClr: begin
                fb_we_o   = 1'b1;
                busy_o    = 1'b1;
                fb_addr_o = clr_addr_q;
            end
            default: ;
        endcase
    end

    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_fig_plot.sv
// Scoreboard bench for fig_plot on a 4x3 framebuffer with a small framebuffer memory model.
module tb_fig_plot;

    localparam int unsigned FB_W   = 4;
    localparam int unsigned FB_H   = 3;
    localparam int unsigned ADDR_W = 4;

    localparam int KDrop   = 0;
    localparam int KReject = 1;
    localparam int KWrite  = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        fig_x_i = '0;
    logic [8:0]        fig_y_i = '0;
    logic [7:0]        fig_h_i = '0;
    logic [7:0]        fig_s_i = '0;
    logic [7:0]        fig_v_i = '0;
    logic              fig_req_i = 1'b0;
    logic              fig_ack_o;
    logic              clear_i = 1'b0;
    logic              busy_o;
    logic [ADDR_W-1:0] fb_addr_o;
    logic              fb_re_o;
    logic [23:0]       fb_rdata_i;
    logic              fb_we_o;
    logic [23:0]       fb_wdata_o;
    logic [15:0]       drop_cnt_o;

    fig_plot #(
        .FB_W  (FB_W),
        .FB_H  (FB_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .fig_x_i   (fig_x_i),
        .fig_y_i   (fig_y_i),
        .fig_h_i   (fig_h_i),
        .fig_s_i   (fig_s_i),
        .fig_v_i   (fig_v_i),
        .fig_req_i (fig_req_i),
        .fig_ack_o (fig_ack_o),
        .clear_i   (clear_i),
        .busy_o    (busy_o),
        .fb_addr_o (fb_addr_o),
        .fb_re_o   (fb_re_o),
        .fb_rdata_i(fb_rdata_i),
        .fb_we_o   (fb_we_o),
        .fb_wdata_o(fb_wdata_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Framebuffer model: synchronous read, write on strobe, optional preload port.
    logic [23:0] mem [16];
    logic [23:0] rdata_q = '0;
    logic        pre_en = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [23:0] pre_data = '0;
    always @(posedge clock) begin
        if (fb_re_o) rdata_q <= mem[fb_addr_o];
        if (fb_we_o) mem[fb_addr_o] <= fb_wdata_o;
        if (pre_en) mem[pre_addr] <= pre_data;
    end
    assign fb_rdata_i = rdata_q;

    typedef struct {
        bit          we;
        logic [3:0]  addr;
        logic [23:0] data;
        int          cyc;
        bit          busy;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input bit we, input logic [3:0] addr, input logic [23:0] data,
                        input int at, input bit busy);
        exp_t e;
        e.we = we; e.addr = addr; e.data = data; e.cyc = at; e.busy = busy;
        sb.push_back(e);
    endtask

    // Monitor: every framebuffer access must match the head of the scoreboard.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (fb_re_o || fb_we_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL fb_unexpected re=%0b we=%0b addr=%0d data=%06h cyc=%0d",
                         fb_re_o, fb_we_o, fb_addr_o, fb_wdata_o, cyc);
            end else begin
                e = sb.pop_front();
                if (fb_we_o !== e.we || fb_re_o !== !e.we || fb_addr_o !== e.addr ||
                    (e.we && fb_wdata_o !== e.data) || busy_o !== e.busy || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL fb_access actual re=%0b we=%0b addr=%0d data=%06h busy=%0b cyc=%0d required we=%0b addr=%0d data=%06h busy=%0b cyc=%0d",
                             fb_re_o, fb_we_o, fb_addr_o, fb_wdata_o, busy_o, cyc,
                             e.we, e.addr, e.data, e.busy, e.cyc);
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the transfer edge with req dropped.
    task automatic send(input logic [7:0] x, input logic [8:0] y, input logic [7:0] h,
                        input logic [7:0] s, input logic [7:0] v, input int kind,
                        input logic [3:0] addr, input logic [23:0] wdata, output int ack_cyc);
        int n = 0;
        fig_x_i = x; fig_y_i = y; fig_h_i = h; fig_s_i = s; fig_v_i = v;
        fig_req_i = 1'b1;
        #1;
        while (!fig_ack_o && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        if (!fig_ack_o) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=0 required=1");
            ack_cyc = -1;
        end else begin
            ack_cyc = cyc;
            if (kind != KDrop) push(1'b0, addr, 24'h0, ack_cyc + 1, 1'b0);
            if (kind == KWrite) push(1'b1, addr, wdata, ack_cyc + 3, 1'b0);
        end
        @(posedge clock); #1;
        fig_req_i = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c, a1, a2, a3, a4, a5, a6, a7;

        // Held in reset with a pending request.
        fig_x_i = 8'd4; fig_req_i = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ack", 32'(fig_ack_o), 32'd0);
        chk("rst_re", 32'(fb_re_o), 32'd0);
        chk("rst_we", 32'(fb_we_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        reset = 1'b1;
        #1;
        chk("release_ack", 32'(fig_ack_o), 32'd1);
        fig_req_i = 1'b0;
        @(posedge clock); #1;

        // Clear sweep with a request held across it.
        clear_i = 1'b1;
        c = cyc;
        @(posedge clock); #1;
        clear_i = 1'b0;
        for (int i = 0; i < 12; i++) push(1'b1, 4'(i), 24'h0, c + 2 + i, 1'b1);
        send(8'd0, 9'd0, 8'd1, 8'd1, 8'd0, KReject, 4'd0, 24'h0, a1);
        chk("ack_after_clear", 32'(a1), 32'(c + 14));
        @(posedge clock); #1;
        @(posedge clock); #1;

        // Stored V of 250 at address 5.
        pre_en = 1'b1; pre_addr = 4'd5; pre_data = 24'h0000FA;
        @(posedge clock); #1;
        pre_en = 1'b0;

        send(8'd2, 9'd1, 8'd100, 8'd255, 8'd200, KWrite, 4'd6, 24'h64FFC8, a1);
        send(8'd2, 9'd1, 8'd100, 8'd255, 8'd200, KReject, 4'd6, 24'h0, a2);
        chk("gap_write", 32'(a2 - a1), 32'd4);
        send(8'd1, 9'd1, 8'd7, 8'd8, 8'd200, KReject, 4'd5, 24'h0, a3);
        chk("gap_reject_eq", 32'(a3 - a2), 32'd3);
        send(8'd4, 9'd0, 8'd1, 8'd1, 8'd9, KDrop, 4'd0, 24'h0, a4);
        chk("gap_reject_dim", 32'(a4 - a3), 32'd3);
        send(8'd0, 9'd511, 8'd1, 8'd1, 8'd9, KDrop, 4'd0, 24'h0, a5);
        chk("gap_drop", 32'(a5 - a4), 32'd1);
        chk("drop_cnt", 32'(drop_cnt_o), 32'd2);
        send(8'd3, 9'd2, 8'd1, 8'd2, 8'd3, KWrite, 4'd11, 24'h010203, a6);
        chk("gap_drop2", 32'(a6 - a5), 32'd1);
        repeat (4) @(posedge clock);
        #1;

        // Clear arriving during CMP of a brighter pixel, then reset mid-sweep.
        send(8'd1, 9'd2, 8'hAA, 8'hBB, 8'd9, KWrite, 4'd9, 24'hAABB09, a7);
        @(posedge clock); #1;
        clear_i = 1'b1;
        @(posedge clock); #1;
        clear_i = 1'b0;
        for (int i = 0; i < 12; i++) push(1'b1, 4'(i), 24'h0, a7 + 5 + i, 1'b1);
        repeat (7) @(posedge clock);
        #1;
        chk("mid_clr_busy", 32'(busy_o), 32'd1);
        reset = 1'b0;
        sb.delete();
        #1;
        chk("abort_we", 32'(fb_we_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_addr", 32'(fb_addr_o), 32'd0);
        chk("abort_drop", 32'(drop_cnt_o), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        chk("post_busy", 32'(busy_o), 32'd0);
        fig_x_i = 8'd4; fig_req_i = 1'b1;
        #1;
        chk("post_ack", 32'(fig_ack_o), 32'd1);
        fig_req_i = 1'b0;
        @(posedge clock); #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
